// File: rtl/neural_soc_pio_pkg.sv
// Shared definitions for the software-to-hardware PIO slice.
//   - Avalon word addresses of the four slave registers
//   - bit positions inside the STATUS word
//   - state encoding of the valid/ack handshake FSM
package neural_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    localparam int STAT_PENDING = 0;
    localparam int STAT_OVERRUN = 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } hs_state_t;

endpackage

// File: rtl/neural_soc_sw_handshake.sv
// Valid/ack handshake that tells fabric logic a new control word arrived,
// plus the sticky overrun flag raised when software replaces a word that
// fabric has not yet acknowledged.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   update   accepted write to DATA, OUTSET or OUTCLEAR this cycle
//   ack      fabric acknowledge, meaningful only while valid is high
//   ovr_clr  software W1C request for the overrun flag
//   valid    high while an unacknowledged word is pending
//   overrun  sticky: a pending word was replaced before it was acknowledged
module neural_soc_sw_handshake
    import neural_soc_pio_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic update,
    input  logic ack,
    input  logic ovr_clr,
    output logic valid,
    output logic overrun
);

    hs_state_t state;
    hs_state_t next_state;
    logic      ovr_set;

    // NOTE: state is written with non-blocking assignments so every register
    // in the design samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        ovr_set    = 1'b0;
        case (state)
            IDLE: begin
                // An ack with nothing pending is simply ignored.
                if (update) begin
                    next_state = PENDING;
                end
            end
            PENDING: begin
                if (update) begin
                    // With a same-cycle ack the old word was consumed and the
                    // new one becomes pending; without it, the old one is lost.
                    if (!ack) begin
                        ovr_set = 1'b1;
                    end
                end else if (ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Set has priority over the software clear so a loss is never hidden.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    assign valid = (state == PENDING);

endmodule

// File: rtl/neural_soc_from_sw_sig.sv
// Avalon-MM slave output port: Nios software writes a control word that
// drives out_port into fabric logic, with a valid/ack handshake announcing
// each update and a STATUS register exposing pending/overrun.
// Ports:
//   clk, reset             system clock; synchronous active-high reset
//   address, chipselect,   Avalon-MM slave, zero wait states;
//   write_n, writedata     write accepted when chipselect & ~write_n
//   readdata               registered every cycle from the address mux
//   out_port               control word to fabric
//   out_valid, out_ack     handshake with the consuming fabric logic
module neural_soc_from_sw_sig
    import neural_soc_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack
);

    logic                  wr_en;
    logic                  update;
    logic                  ovr_clr;
    logic                  overrun;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic [31:0]           rd_mux;

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[DATA_WIDTH-1:0];

    // Every data-register write counts as an update, even if it leaves the
    // value unchanged, so software can re-announce the same word.
    assign update  = wr_en && (address != ADDR_STATUS);
    assign ovr_clr = wr_en && (address == ADDR_STATUS) && writedata[STAT_OVERRUN];

    // Bits above the data field are don't-care on every address.
    if (DATA_WIDTH < 32) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^writedata[31:DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     out_port <= wr_bits;
                ADDR_OUTSET:   out_port <= out_port | wr_bits;
                ADDR_OUTCLEAR: out_port <= out_port & ~wr_bits;
                default:       out_port <= out_port;
            endcase
        end
    end

    neural_soc_sw_handshake u_handshake (
        .clk     (clk),
        .reset   (reset),
        .update  (update),
        .ack     (out_ack),
        .ovr_clr (ovr_clr),
        .valid   (out_valid),
        .overrun (overrun)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[DATA_WIDTH-1:0] = out_port;
            ADDR_STATUS: begin
                rd_mux[STAT_PENDING] = out_valid;
                rd_mux[STAT_OVERRUN] = overrun;
            end
            default: rd_mux = '0;
        endcase
    end

    // Registered unconditionally: fixed 1-cycle latency, no read strobe needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule
